// File: rtl/apb_wait_regbank.sv
// APB3 slave register bank: 13 scratch words, doorbell, read-only ID and CTRL with IRQ control.
// Latency: access phase lasts CTRL.WAIT+1 cycles (1..8); writes commit on the edge ending PREADY=1.
// Backpressure: PREADY held low while the wait counter runs; PSEL dropping before PREADY aborts.
module apb_wait_regbank #(
    parameter logic [31:0] ID_VALUE   = 32'h0A5B_0001,
    parameter logic [2:0]  RESET_WAIT = 3'd0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state;
    state_t      state_d;
    logic [2:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [31:0] regs [14];
    logic [2:0]  ctrl_wait;
    logic        irq_en;
    logic        irq_pend;
    logic [3:0]  idx;
    logic        err;
    logic        commit;
    logic [31:0] rdata;

    assign idx    = addr_q[5:2];
    assign err    = (addr_q[31:6] != 26'd0) || (addr_q[1:0] != 2'b00)
                    || (write_q && (idx == 4'd14));
    assign commit = PREADY && write_q && !err;
    assign IRQ    = irq_pend && irq_en;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The setup cycle is recognised straight off the bus, so a transfer whose
    // setup follows a completed access is taken without an idle cycle.
    always_comb begin
        state = IDLE;
        if (PSEL && !PENABLE) begin
            state = SETUP;
        end else if ((state_q == ACCESS) && PSEL && PENABLE) begin
            state = ACCESS;
        end
        state_d = IDLE;
        case (state)
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (wait_cnt == 3'd0) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        if ((state == ACCESS) && (wait_cnt == 3'd0)) begin
            PREADY  = 1'b1;
            PSLVERR = err;
            if (!write_q && !err) begin
                PRDATA = rdata;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (idx <= 4'd13) begin
            rdata = regs[idx];
        end else if (idx == 4'd14) begin
            rdata = ID_VALUE;
        end else begin
            rdata = {22'd0, irq_pend, irq_en, 5'd0, ctrl_wait};
        end
    end

    // Wait count is captured at setup, so a CTRL write only affects later transfers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            write_q  <= 1'b0;
        end else if (state == SETUP) begin
            wait_cnt <= ctrl_wait;
            addr_q   <= PADDR;
            wdata_q  <= PWDATA;
            write_q  <= PWRITE;
        end else if ((state == ACCESS) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < 14; i++) begin
                regs[i] <= 32'h0;
            end
            ctrl_wait <= RESET_WAIT;
            irq_en    <= 1'b0;
            irq_pend  <= 1'b0;
        end else if (commit) begin
            if (idx <= 4'd13) begin
                regs[idx] <= wdata_q;
            end
            if (idx == 4'd15) begin
                ctrl_wait <= wdata_q[2:0];
                irq_en    <= wdata_q[8];
                if (wdata_q[9]) begin
                    irq_pend <= 1'b0;
                end
            end
            // Doorbell set is last so it wins over a clear in the same commit.
            if ((idx == 4'd13) && irq_en) begin
                irq_pend <= 1'b1;
            end
        end
    end
endmodule

// File: doc/apb_wait_regbank.md
APB_WAIT_REGBANK -- requirements
Module: apb_wait_regbank

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h0A5B_0001, giving the constant returned by register 14.
REQ-002 SHALL have parameter RESET_WAIT, default 3'd0, giving the reset value of CTRL[2:0].
REQ-003 SHALL have port PCLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port PRESET, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port PSEL, input, 1 bit: APB3 slave select, driven from one bit of the bridge PSEL bus.
REQ-006 SHALL have port PENABLE, input, 1 bit: APB access phase.
REQ-007 SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port PADDR, input, 32 bits: byte address.
REQ-009 SHALL have port PWDATA, input, 32 bits: write data.
REQ-010 SHALL have port PRDATA, output, 32 bits: read data.
REQ-011 SHALL have port PREADY, output, 1 bit: transfer complete.
REQ-012 SHALL have port PSLVERR, output, 1 bit: transfer error.
REQ-013 SHALL have port IRQ, output, 1 bit: doorbell interrupt, level.

Function
REQ-014 Register map (index = PADDR[5:2]) SHALL be: 0-12 scratch RW; 13 DOORBELL RW; 14 ID RO, returns ID_VALUE; 15 CTRL.
REQ-015 CTRL SHALL be: [2:0] WAIT (RW); [8] IRQ_EN (RW); [9] IRQ_PEND (RO, write-1-clears); other bits read 0.
REQ-016 FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-017 IDLE SHALL go to SETUP on PSEL=1 with PENABLE=0.
REQ-018 SETUP SHALL always go to ACCESS on the next cycle.
REQ-019 ACCESS SHALL go to IDLE on PREADY=1, or SETUP if PSEL=1 with PENABLE=0 on that cycle.
REQ-020 In SETUP, the wait counter SHALL load CTRL[2:0] and latch the PADDR, PWRITE and PWDATA values used by the transfer.
REQ-021 In ACCESS, while the counter is non-zero, it SHALL decrement each cycle with PREADY=0.
REQ-022 PREADY SHALL be 1 only in ACCESS with counter==0, giving WAIT extra cycles in the access phase (0-7).
REQ-023 A CTRL write SHALL affect wait states from the next transfer only.
REQ-024 A write SHALL commit at the rising edge ending the PREADY=1 cycle.
REQ-025 PRDATA SHALL carry register data only while PREADY=1 and the transfer is a non-error read; otherwise it SHALL be 32'h0.
REQ-026 PSLVERR SHALL be asserted only with PREADY=1, when PADDR[31:6]!=0, PADDR[1:0]!=0, or the transfer writes index 14.
REQ-027 Errored writes SHALL have no effect; errored reads SHALL return 0.
REQ-028 A non-error write to DOORBELL with CTRL[8]=1 SHALL set IRQ_PEND.
REQ-029 A write of CTRL with bit9=1 SHALL clear IRQ_PEND.
REQ-030 When set and clear of IRQ_PEND occur in the same transfer, set SHALL win.
REQ-031 IRQ SHALL equal IRQ_PEND AND IRQ_EN.
REQ-032 PSEL deasserting in SETUP or ACCESS before PREADY SHALL abort the transfer: FSM to IDLE, no register update, PREADY and PSLVERR stay 0.
REQ-033 PENABLE=1 seen in IDLE (no setup phase) SHALL be ignored: PREADY stays 0.

Reset
REQ-034 While PRESET=1 (asynchronous), FSM SHALL be IDLE and the counter 0.
REQ-035 While PRESET=1, regs 0-13 SHALL be 0, CTRL SHALL be {IRQ_PEND=0, IRQ_EN=0, WAIT=RESET_WAIT}, and PRDATA, PREADY, PSLVERR and IRQ SHALL be 0.
REQ-036 Reset asserted mid-transfer SHALL discard the transfer with no write committed.
REQ-037 After PRESET falls, the first setup SHALL be accepted on the next rising edge.

Verification
REQ-038 Bench SHALL cover: write 32'hDEADBEEF to 0x04 with WAIT=0, then read 0x04 -> each access phase lasts exactly 1 cycle with PREADY=1, read returns DEADBEEF, PSLVERR=0.
REQ-039 Bench SHALL cover: write CTRL=0x5, then read 0x08 -> PREADY low for 5 access cycles then high on the 6th; a CTRL write to WAIT=0 made during that read does not shorten it.
REQ-040 Bench SHALL cover: read 0x38 -> ID_VALUE; write 0x38 -> PSLVERR=1 and ID unchanged; access 0x40 -> PSLVERR=1 and PRDATA=0; access 0x06 -> PSLVERR=1.
REQ-041 Bench SHALL cover: CTRL=0x100, write DOORBELL -> IRQ=1 on the cycle after the commit; write CTRL=0x300 -> IRQ=0; with IRQ_EN=0 a doorbell write leaves IRQ=0.
REQ-042 Bench SHALL cover: PSEL dropped in the 2nd wait cycle of a write to 0x10 (WAIT=3) -> reg 0x10 unchanged and the next transfer completes normally.
REQ-043 Bench SHALL cover: PRESET pulsed during the wait cycles of a write -> all outputs 0 immediately, registers 0, CTRL WAIT=RESET_WAIT.
